// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_tx_arbiter                                               |
// | Purpose  : Two-requester byte arbiter feeding a single UART transmitter,  |
// |            with burst-limited fairness. Optional macro UART_ARB_STATS_EN |
// |            enables the per-requester sent-byte counters cnt0/cnt1.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module uart_tx_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req0_empty,
   input  logic                  req1_empty,
   input  logic [DATA_WIDTH-1:0] req0_dout,
   input  logic [DATA_WIDTH-1:0] req1_dout,
   input  logic                  req0_valid,
   input  logic                  req1_valid,
   output logic                  req0_rd_en,
   output logic                  req1_rd_en,
   input  logic                  tx_ready,
   output logic                  tx_send,
   output logic [DATA_WIDTH-1:0] tx_data,
   output logic [1:0]            grant,
   output logic                  busy,
   output logic [15:0]           cnt0,
   output logic [15:0]           cnt1
);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      READ       = 3'd1,
      WAIT_VALID = 3'd2,
      SEND       = 3'd3,
      WAIT_ACK   = 3'd4
   } state_t;

   localparam logic [7:0] c_max_burst = 8'(MAX_BURST);

   state_t     r_state;
   logic [7:0] r_burst_cnt;
   logic [1:0] w_req_ne;
   logic [1:0] w_next_grant;
   logic       w_clear_burst;
   logic       w_owner_valid;

   assign w_req_ne      = {~req1_empty, ~req0_empty};
   assign w_owner_valid = (grant[0] & req0_valid) | (grant[1] & req1_valid);

   // Only meaningful when at least one requester is non-empty.
   always_comb begin
      w_next_grant  = grant;
      w_clear_burst = 1'b0;
      if (grant == 2'b00) begin
         w_next_grant  = w_req_ne[0] ? 2'b01 : 2'b10;
         w_clear_burst = 1'b1;
      end else if (((w_req_ne & grant) != 2'b00) && (r_burst_cnt < c_max_burst)) begin
         w_next_grant  = grant;
      end else if ((w_req_ne & ~grant) != 2'b00) begin
         w_next_grant  = ~grant;
         w_clear_burst = 1'b1;
      end else begin
         w_clear_burst = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_burst_cnt <= 8'd0;
         req0_rd_en  <= 1'b0;
         req1_rd_en  <= 1'b0;
         tx_send     <= 1'b0;
         tx_data     <= '0;
         grant       <= 2'b00;
         busy        <= 1'b0;
      end else begin
         req0_rd_en <= 1'b0;
         req1_rd_en <= 1'b0;
         tx_send    <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (tx_ready && (w_req_ne != 2'b00)) begin
                  grant      <= w_next_grant;
                  req0_rd_en <= w_next_grant[0];
                  req1_rd_en <= w_next_grant[1];
                  busy       <= 1'b1;
                  r_state    <= READ;
                  if (w_clear_burst) r_burst_cnt <= 8'd0;
               end
            end
            READ: r_state <= WAIT_VALID;
            WAIT_VALID: begin
               if (w_owner_valid) begin
                  tx_data <= grant[0] ? req0_dout : req1_dout;
                  tx_send <= 1'b1;
                  r_state <= SEND;
                  if (r_burst_cnt < c_max_burst) r_burst_cnt <= r_burst_cnt + 8'd1;
               end
            end
            SEND: r_state <= WAIT_ACK;
            WAIT_ACK: begin
               // The UART must visibly drop ready before the next byte is issued.
               if (!tx_ready) begin
                  busy    <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: begin
               busy    <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

`ifdef UART_ARB_STATS_EN
   logic [15:0] r_cnt0;
   logic [15:0] r_cnt1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt0 <= 16'd0;
         r_cnt1 <= 16'd0;
      end else if (tx_send) begin
         if (grant[0] && (r_cnt0 != 16'hFFFF)) r_cnt0 <= r_cnt0 + 16'd1;
         if (grant[1] && (r_cnt1 != 16'hFFFF)) r_cnt1 <= r_cnt1 + 16'd1;
      end
   end

   assign cnt0 = r_cnt0;
   assign cnt1 = r_cnt1;
`else
   assign cnt0 = 16'd0;
   assign cnt1 = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_uart_tx_arbiter                                            |
// | Purpose  : Directed self-checking bench for uart_tx_arbiter with FIFO    |
// |            and UART behavioural models.                                  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_empty, req1_empty;
   logic [7:0]  req0_dout = 8'h00, req1_dout = 8'h00;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic        req0_rd_en, req1_rd_en;
   logic        tx_ready;
   logic        tx_send;
   logic [7:0]  tx_data;
   logic [1:0]  grant;
   logic        busy;
   logic [15:0] cnt0, cnt1;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.DATA_WIDTH(8), .MAX_BURST(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_empty(req0_empty), .req1_empty(req1_empty),
      .req0_dout(req0_dout), .req1_dout(req1_dout),
      .req0_valid(req0_valid), .req1_valid(req1_valid),
      .req0_rd_en(req0_rd_en), .req1_rd_en(req1_rd_en),
      .tx_ready(tx_ready), .tx_send(tx_send), .tx_data(tx_data),
      .grant(grant), .busy(busy), .cnt0(cnt0), .cnt1(cnt1)
   );

   // FIFO models: write pointers owned by the stimulus, read side by the model.
   logic [7:0] mem0 [0:63];
   logic [7:0] mem1 [0:63];
   int wp0 = 0, rp0 = 0, wp1 = 0, rp1 = 0;
   int rd_viol = 0;
   assign req0_empty = (wp0 == rp0);
   assign req1_empty = (wp1 == rp1);

   always @(posedge clk) begin
      req0_valid <= 1'b0;
      req1_valid <= 1'b0;
      if (req0_rd_en) begin
         if (wp0 == rp0) rd_viol <= rd_viol + 1;
         else begin
            req0_dout  <= mem0[rp0];
            req0_valid <= 1'b1;
            rp0        <= rp0 + 1;
         end
      end
      if (req1_rd_en) begin
         if (wp1 == rp1) rd_viol <= rd_viol + 1;
         else begin
            req1_dout  <= mem1[rp1];
            req1_valid <= 1'b1;
            rp1        <= rp1 + 1;
         end
      end
   end

   // UART model: busy for a few cycles after each send, or held off by hold_low.
   int   ubusy = 0;
   logic hold_low = 1'b0;
   always @(posedge clk) begin
      if (tx_send) ubusy <= 3;
      else if (ubusy != 0) ubusy <= ubusy - 1;
   end
   assign tx_ready = !hold_low && (ubusy == 0);

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] sent_d [$];
   logic [1:0] sent_g [$];
   int         sent_lat [$];
   int         sent_c [$];
   int         last_rd = -100;
   int         rd_cnt = 0;
   int         seq_viol = 0;
   logic       prev_rd = 1'b0;

   always @(negedge clk) begin
      if (req0_rd_en || req1_rd_en) begin
         if (prev_rd) seq_viol++;
         if (req0_rd_en && req1_rd_en) seq_viol++;
         last_rd = cyc;
         rd_cnt++;
      end
      prev_rd = req0_rd_en || req1_rd_en;
      if (tx_send) begin
         sent_d.push_back(tx_data);
         sent_g.push_back(grant);
         sent_lat.push_back(cyc - last_rd);
         sent_c.push_back(cyc);
      end
   end

   int n_checks = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs === expv) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
   endtask

   task automatic push0(input logic [7:0] d);
      mem0[wp0] = d;
      wp0++;
   endtask

   task automatic push1(input logic [7:0] d);
      mem1[wp1] = d;
      wp1++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_sends(input int n, input int budget, input string tag);
      int k = 0;
      while ((sent_d.size() < n) && (k < budget)) begin
         @(negedge clk);
         k++;
      end
      check(tag, sent_d.size(), n);
   endtask

   logic [7:0] exp_order [8] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'hA0, 8'hA1, 8'h04, 8'h05};
   logic [7:0] exp_t1 [3]    = '{8'h61, 8'h01, 8'h02};

`ifdef UART_ARB_STATS_EN
   localparam int c_exp_cnt0 = 6;
   localparam int c_exp_cnt1 = 2;
`else
   localparam int c_exp_cnt0 = 0;
   localparam int c_exp_cnt1 = 0;
`endif

   initial begin
      int s, t, r, k;
      logic seen;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_outputs", {busy, grant, tx_send, req0_rd_en, req1_rd_en, tx_data}, 32'h0);
      check("rst_cnt", {cnt0, cnt1}, 32'h0);
      rst_n = 1'b1;

      // Single requester, three bytes.
      s = sent_d.size();
      @(negedge clk);
      push0(8'h61); push0(8'h01); push0(8'h02);
      wait_sends(s + 3, 200, "t1_count");
      for (int i = 0; i < 3; i++) begin
         if (sent_d.size() > s + i) begin
            check("t1_data", sent_d[s+i], exp_t1[i]);
            check("t1_grant", sent_g[s+i], 2'b01);
            check("t1_latency", sent_lat[s+i], 2);
         end
      end

      // Burst limit fairness.
      do_reset();
      s = sent_d.size();
      for (int i = 0; i < 6; i++) push0(8'(i));
      push1(8'hA0); push1(8'hA1);
      wait_sends(s + 8, 400, "t2_count");
      for (int i = 0; i < 8; i++) begin
         if (sent_d.size() > s + i) check("t2_order", sent_d[s+i], exp_order[i]);
      end
      if (sent_d.size() > s + 4) check("t2_grant_a0", sent_g[s+4], 2'b10);
      repeat (2) @(negedge clk);
      check("t2_cnt0", cnt0, c_exp_cnt0);
      check("t2_cnt1", cnt1, c_exp_cnt1);

      // Simultaneous requests from reset.
      do_reset();
      s = sent_d.size();
      push0(8'h11); push1(8'h22);
      wait_sends(s + 2, 200, "t3_count");
      if (sent_d.size() >= s + 2) begin
         check("t3_first", sent_d[s], 8'h11);
         check("t3_first_grant", sent_g[s], 2'b01);
         check("t3_second", sent_d[s+1], 8'h22);
      end

      // UART held off.
      do_reset();
      hold_low = 1'b1;
      push0(8'h33); push1(8'h44);
      r = rd_cnt;
      s = sent_d.size();
      repeat (1000) @(negedge clk);
      check("t4_no_rd", rd_cnt - r, 0);
      check("t4_no_send", sent_d.size() - s, 0);
      hold_low = 1'b0;
      t = cyc;
      wait_sends(s + 1, 50, "t4_count");
      if (sent_d.size() > s) begin
         check("t4_latency", sent_c[s] - t, 3);
         check("t4_data", sent_d[s], 8'h33);
      end
      wait_sends(s + 2, 100, "t4_drain");

      // Reset while waiting for read data.
      do_reset();
      s = sent_d.size();
      push0(8'h5A);
      seen = 1'b0;
      k = 0;
      while (!seen && (k < 20)) begin
         @(negedge clk);
         seen = req0_rd_en;
         k++;
      end
      check("t5_rd_seen", seen, 1'b1);
      @(negedge clk);
      check("t5_busy_wv", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      check("t5_rst_outputs", {busy, grant, tx_send, req0_rd_en, req1_rd_en, tx_data}, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      check("t5_no_send", sent_d.size() - s, 0);
      check("t5_idle", busy, 1'b0);

      check("rd_empty_viol", rd_viol, 0);
      check("rd_seq_viol", seq_viol, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, is the byte width of the requester and UART data paths.
REQ-002 Parameter MAX_BURST, default 4, is the maximum number of consecutive bytes granted to one requester while the other is waiting; legal range 1..255.
REQ-003 clk  input  1  rising-edge system clock, the only clock.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req0_empty, req1_empty  input  1 each  requester FIFO empty flags.
REQ-006 req0_dout, req1_dout  input  DATA_WIDTH each  requester FIFO read data.
REQ-007 req0_valid, req1_valid  input  1 each  requester FIFO read-data valid, asserted one cycle after rd_en.
REQ-008 req0_rd_en, req1_rd_en  output  1 each  requester FIFO read strobe.
REQ-009 tx_ready  input  1  UART transmitter idle and able to accept a byte.
REQ-010 tx_send  output  1  one-cycle send strobe to the UART transmitter.
REQ-011 tx_data  output  DATA_WIDTH  byte presented to the UART transmitter; stable from tx_send until the next latch.
REQ-012 grant  output  2  one-hot current owner (bit0 = req0, bit1 = req1); 2'b00 when no owner has been selected.
REQ-013 busy  output  1  high in every state other than IDLE.
REQ-014 cnt0, cnt1  output  16 each  bytes sent per requester (see Configuration).

Function
REQ-015 FSM states: IDLE, READ, WAIT_VALID, SEND, WAIT_ACK; all outputs registered.
REQ-016 IDLE: when tx_ready=1 and at least one reqN_empty=0, select the owner per REQ-017 and go to READ; otherwise stay.
REQ-017 Arbitration: keep the current owner if it is non-empty and burst_cnt < MAX_BURST; otherwise switch to the other requester if it is non-empty; otherwise, if only the current owner is non-empty, keep it and clear burst_cnt; with no prior owner, req0 wins a tie.
REQ-018 burst_cnt (8 bit) increments on each tx_send, clears on an owner change, and never exceeds MAX_BURST.
REQ-019 READ: assert the owner's rd_en for exactly one cycle, then go to WAIT_VALID; the other requester's rd_en stays 0.
REQ-020 WAIT_VALID: on the owner's valid=1, latch the owner's dout into tx_data and go to SEND; valid from the non-owner is ignored; wait indefinitely.
REQ-021 SEND: tx_send=1 for exactly one cycle, then go to WAIT_ACK.
REQ-022 WAIT_ACK: on tx_ready=0 go to IDLE; a new byte is never issued until tx_ready has fallen and risen again.
REQ-023 Latency: the IDLE decision edge is followed by rd_en on cycle +1, valid on cycle +2, and tx_send on cycle +3.
REQ-024 reqN_rd_en is never asserted while reqN_empty=1 at the decision edge, and rd_en is never asserted in two consecutive cycles.
REQ-025 A requester going empty mid-transaction has no effect on a byte already read; that byte is still sent.

Reset
REQ-026 When rst_n=0: state=IDLE, rd_en=0, tx_send=0, tx_data=0, grant=2'b00, busy=0, burst_cnt=0, cnt0=cnt1=0, asynchronously.
REQ-027 Reset asserted mid-transaction discards any latched byte; after release the FSM restarts from IDLE with no owner.

Configuration
REQ-028 Macro UART_ARB_STATS_EN: when defined, cnt0/cnt1 increment on each tx_send for the owning requester and saturate at 16'hFFFF.
REQ-029 Without UART_ARB_STATS_EN, cnt0/cnt1 are constant 0 and no counter logic is instantiated; the ports remain present.

Verification
REQ-030 Bench: req0 holds 0x61, 0x01, 0x02 and req1 is empty -> UART receives 0x61, 0x01, 0x02 in order, grant=2'b01 throughout, and tx_send occurs 3 cycles after each IDLE decision.
REQ-031 Bench: req0 holds 6 bytes 0x00..0x05 and req1 holds 0xA0, 0xA1, with MAX_BURST=4 -> send order 00, 01, 02, 03, A0, A1, 04, 05.
REQ-032 Bench: both requesters become non-empty on the same cycle from reset -> req0 is served first and grant=2'b01.
REQ-033 Bench: hold tx_ready=0 for 1000 cycles while both requesters are non-empty -> no rd_en and no tx_send occur; the first tx_send follows 3 cycles after tx_ready rises.
REQ-034 Bench: pulse rst_n low during WAIT_VALID -> all outputs return to their reset values immediately, and the pending byte is never sent.
REQ-035 Bench: with UART_ARB_STATS_EN defined, after the REQ-031 run cnt0=6 and cnt1=2; without the macro, both read 0.
